cmos_roi_crop: RTL and testbench

- Sits directly downstream of the OV5640 capture stage, in the cam_pclk domain.
- Consumes the gated vsync/href/valid/RGB565 stream and tracks pixel column and line position.
- Forwards only pixels inside a fixed region of interest (ROI), with start-of-frame, end-of-line and end-of-frame markers for the frame-buffer writer.
- Measures the incoming frame geometry and flags frames that are too short.

---
 rtl/cmos_roi_crop.sv | 173 +++++++++++++++++
 tb/tb_cmos_roi_crop.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_roi_crop.sv
// Purpose: crop the OV5640 RGB565 stream to a fixed ROI, add SOF/EOL/EOF markers, measure frame geometry.
// Latency: 1 cam_pclk from accepted pixel to out_valid/out_data; out_vsync is in_vsync delayed 1.
// Backpressure: none; the camera cannot be stalled, so every accepted pixel is forwarded or dropped.
module cmos_roi_crop #(
    parameter int H_START = 0,
    parameter int H_SIZE  = 640,
    parameter int V_START = 0,
    parameter int V_SIZE  = 480,
    parameter int CNT_W   = 12
) (
    input  logic             cam_pclk,
    input  logic             rst_n,
    input  logic             in_vsync,
    input  logic             in_href,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    input  logic             crop_en,
    output logic             out_vsync,
    output logic             out_valid,
    output logic [15:0]      out_data,
    output logic             out_sof,
    output logic             out_eol,
    output logic             out_eof,
    output logic [CNT_W-1:0] meas_width,
    output logic [CNT_W-1:0] meas_height,
    output logic             short_frame
);

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        IN_FRAME  = 1'b1
    } state_t;

    // Offsets are one bit wider than the counters plus a sign bit, so ROI
    // bounds near the top of the counter range cannot wrap.
    localparam int OFF_W = CNT_W + 2;
    localparam logic [OFF_W-1:0] H_LO   = OFF_W'(H_START);
    localparam logic [OFF_W-1:0] V_LO   = OFF_W'(V_START);
    localparam logic [OFF_W-1:0] H_W    = OFF_W'(H_SIZE);
    localparam logic [OFF_W-1:0] V_H    = OFF_W'(V_SIZE);
    localparam logic [OFF_W-1:0] H_LAST = OFF_W'(H_SIZE - 1);
    localparam logic [OFF_W-1:0] V_LAST = OFF_W'(V_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             vs_q, hr_q;
    logic             en_q;
    logic             eof_seen;
    logic [CNT_W-1:0] col_cnt, row_cnt, last_width;

    logic             frame_start, line_end, pixel;
    logic             active, en_eff, take;
    logic [CNT_W-1:0] col_use, row_use;
    logic [OFF_W-1:0] h_off, v_off;
    logic             h_in, v_in;
    logic             fwd, sof_hit, eol_hit, eof_hit;

    // Event decode against the registered copy of the sync inputs.
    always_comb begin
        frame_start = in_vsync & ~vs_q;
        line_end    = hr_q & ~in_href;
        pixel       = in_valid & in_href;
    end

    // FSM next state: any frame start lands in (or stays in) IN_FRAME.
    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            state_d = IN_FRAME;
        end
    end

    // ROI decode; a pixel coincident with frame start is column 0, row 0 of the new frame.
    always_comb begin
        active  = (state_q == IN_FRAME) | frame_start;
        en_eff  = frame_start ? crop_en : en_q;
        col_use = frame_start ? '0 : col_cnt;
        row_use = frame_start ? '0 : row_cnt;
        h_off   = {2'b00, col_use} - H_LO;
        v_off   = {2'b00, row_use} - V_LO;
        h_in    = ~h_off[OFF_W-1] & (h_off < H_W);
        v_in    = ~v_off[OFF_W-1] & (v_off < V_H);
        take    = active & pixel;
        fwd     = take & (~en_eff | (h_in & v_in));
        sof_hit = take & en_eff & h_in & v_in & (h_off == '0) & (v_off == '0);
        eol_hit = take & en_eff & v_in & (h_off == H_LAST);
        eof_hit = eol_hit & (v_off == V_LAST);
    end

    // FSM state register and sync-input history.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_SYNC;
            vs_q    <= 1'b0;
            hr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            vs_q    <= in_vsync;
            hr_q    <= in_href;
        end
    end

    // Column/line counters; frame start overrides a coincident line end.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt    <= '0;
            row_cnt    <= '0;
            last_width <= '0;
        end else if (frame_start) begin
            col_cnt    <= CNT_W'(pixel);
            row_cnt    <= '0;
            last_width <= '0;
        end else if (state_q == IN_FRAME) begin
            if (line_end) begin
                col_cnt <= '0;
                if (col_cnt != '0) begin
                    last_width <= col_cnt;
                    if (row_cnt != CNT_MAX) begin
                        row_cnt <= row_cnt + 1'b1;
                    end
                end
            end else if (pixel && col_cnt != CNT_MAX) begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    // Per-frame bookkeeping: mode latch, geometry report, short-frame detection.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            en_q        <= 1'b0;
            eof_seen    <= 1'b0;
            meas_width  <= '0;
            meas_height <= '0;
            short_frame <= 1'b0;
        end else begin
            short_frame <= 1'b0;
            if (frame_start) begin
                en_q     <= crop_en;
                eof_seen <= eof_hit;
                if (state_q == IN_FRAME) begin
                    meas_width  <= last_width;
                    meas_height <= row_cnt;
                    short_frame <= en_q & ~eof_seen;
                end
            end else if (eof_hit) begin
                eof_seen <= 1'b1;
            end
        end
    end

    // Output pipeline stage; data holds its last value between strobes.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            out_vsync <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            out_vsync <= in_vsync;
            out_valid <= fwd;
            out_sof   <= sof_hit;
            out_eol   <= eol_hit;
            out_eof   <= eof_hit;
            if (fwd) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_cmos_roi_crop.sv
// Purpose: directed bench for cmos_roi_crop with a queue-based scoreboard and a free-running monitor.
// Latency: expects each output exactly one cam_pclk after its input pixel.
// Backpressure: none; the stimulus streams pixels freely.
module tb_cmos_roi_crop;

    localparam int CW = 12;

    logic          cam_pclk = 1'b0;
    logic          rst_n    = 1'b0;
    logic          in_vsync = 1'b0;
    logic          in_href  = 1'b0;
    logic          in_valid = 1'b0;
    logic [15:0]   in_data  = '0;
    logic          crop_en  = 1'b0;
    logic          out_vsync, out_valid, out_sof, out_eol, out_eof, short_frame;
    logic [15:0]   out_data;
    logic [CW-1:0] meas_width, meas_height;

    cmos_roi_crop #(
        .H_START(2), .H_SIZE(4), .V_START(1), .V_SIZE(2), .CNT_W(CW)
    ) dut (
        .cam_pclk(cam_pclk), .rst_n(rst_n),
        .in_vsync(in_vsync), .in_href(in_href), .in_valid(in_valid), .in_data(in_data),
        .crop_en(crop_en),
        .out_vsync(out_vsync), .out_valid(out_valid), .out_data(out_data),
        .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
        .meas_width(meas_width), .meas_height(meas_height), .short_frame(short_frame)
    );

    always #5 cam_pclk = ~cam_pclk;

    typedef struct {
        logic [15:0] dat;
        logic        sof;
        logic        eol;
        logic        eof;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   n_out = 0;
    int   exp_short_cyc = -10;
    bit   m_active = 1'b0;
    bit   m_en     = 1'b0;
    bit   m_eof_seen = 1'b0;
    logic vs_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Cycle stamp and a reference copy of in_vsync as seen by the DUT.
    always @(posedge cam_pclk) begin
        cyc     <= cyc + 1;
        vs_prev <= in_vsync;
    end

    // Monitor: pops the scoreboard on every out_valid, checks markers and pulses each cycle.
    always @(negedge cam_pclk) begin
        exp_t e;
        chk("short_frame", {31'b0, short_frame}, {31'b0, (cyc == exp_short_cyc)});
        if (rst_n) chk("out_vsync", {31'b0, out_vsync}, {31'b0, vs_prev});
        if (out_valid) begin
            n_out++;
            if (sb.size() == 0) begin
                chk("unexpected_valid", {16'b0, out_data}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("out_data", {16'b0, out_data}, {16'b0, e.dat});
                chk("out_sof", {31'b0, out_sof}, {31'b0, e.sof});
                chk("out_eol", {31'b0, out_eol}, {31'b0, e.eol});
                chk("out_eof", {31'b0, out_eof}, {31'b0, e.eof});
                chk("latency", cyc, e.cyc);
            end
        end else begin
            chk("marker_without_valid", {29'b0, out_sof, out_eol, out_eof}, 32'd0);
        end
    end

    // One pixel; ROI for this bench is cols 2..5, rows 1..2.
    task automatic pix(input int row, input int col);
        exp_t e;
        bit   hit;
        @(negedge cam_pclk);
        in_href  = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'(row * 16 + col);
        if (m_active) begin
            hit = !m_en || (col >= 2 && col <= 5 && row >= 1 && row <= 2);
            if (hit) begin
                e.dat = 16'(row * 16 + col);
                e.sof = m_en && row == 1 && col == 2;
                e.eol = m_en && col == 5;
                e.eof = m_en && col == 5 && row == 2;
                e.cyc = cyc + 1;
                if (e.eof) m_eof_seen = 1'b1;
                sb.push_back(e);
            end
        end
    endtask

    task automatic line_end_gap();
        @(negedge cam_pclk);
        in_href  = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge cam_pclk);
    endtask

    task automatic send_line(input int row, input int len);
        for (int c = 0; c < len; c++) pix(row, c);
        line_end_gap();
    endtask

    task automatic frame8x4();
        for (int r = 0; r < 4; r++) send_line(r, 8);
    endtask

    task automatic vsync_pulse(input bit c);
        @(negedge cam_pclk);
        in_vsync = 1'b1;
        crop_en  = c;
        if (m_active && m_en && !m_eof_seen) exp_short_cyc = cyc + 1;
        m_active   = 1'b1;
        m_en       = c;
        m_eof_seen = 1'b0;
        repeat (2) @(negedge cam_pclk);
        in_vsync = 1'b0;
        repeat (2) @(negedge cam_pclk);
    endtask

    task automatic chk_meas(input string tag, input int w, input int h);
        chk({tag, "_meas_width"}, {20'b0, meas_width}, w);
        chk({tag, "_meas_height"}, {20'b0, meas_height}, h);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        repeat (3) @(negedge cam_pclk);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_out_data", {16'b0, out_data}, 0);
        chk("rst_markers", {29'b0, out_sof, out_eol, out_eof}, 0);
        chk_meas("rst", 0, 0);
        rst_n = 1'b1;

        // Pixels before the first vsync are discarded.
        send_line(0, 8);

        // Frames 1 and 2: full 8x4 crop.
        vsync_pulse(1'b1);
        frame8x4();
        vsync_pulse(1'b1);
        snap = n_out;
        frame8x4();
        chk("frame2_count", n_out - snap, 8);

        // Frame 3: geometry of frame 2, then a 2-line frame that never reaches EOF.
        vsync_pulse(1'b1);
        chk_meas("f3", 8, 4);
        send_line(0, 8);
        send_line(1, 8);

        // Frame 4: pass-through; crop_en toggled mid-frame has no effect until next start.
        vsync_pulse(1'b0);
        chk_meas("f4", 8, 2);
        snap = n_out;
        send_line(0, 8);
        crop_en = 1'b1;
        send_line(1, 8);
        send_line(2, 8);
        send_line(3, 8);
        chk("frame4_count", n_out - snap, 32);

        // Frame 5: ROI row 1 is only 3 pixels long.
        vsync_pulse(1'b1);
        chk_meas("f5", 8, 4);
        snap = n_out;
        send_line(0, 8);
        send_line(1, 3);
        send_line(2, 8);
        send_line(3, 8);
        chk("frame5_count", n_out - snap, 5);

        // Frame 6: reset mid-line, outputs must drop at once.
        vsync_pulse(1'b1);
        send_line(0, 8);
        pix(1, 0);
        pix(1, 1);
        @(negedge cam_pclk);
        #2;
        rst_n    = 1'b0;
        m_active = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 0);
        chk("midrst_out_data", {16'b0, out_data}, 0);
        chk_meas("midrst", 0, 0);
        for (int c = 2; c < 8; c++) begin
            pix(1, c);
            if (c == 3) rst_n = 1'b1;
        end
        line_end_gap();
        send_line(2, 8);
        send_line(3, 8);

        // Frame 7: first frame after recovery behaves like frame 2.
        vsync_pulse(1'b1);
        snap = n_out;
        frame8x4();
        chk("frame7_count", n_out - snap, 8);
        vsync_pulse(1'b1);
        chk_meas("f8", 8, 4);

        repeat (5) @(negedge cam_pclk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
